// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetches opcode, register byte and an optional
// little-endian immediate over a ready/request byte bus, then executes MOV/ADD forms.
module seq_ctrl #(
  parameter int BYTE_SIZE = 8,
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 4,
  localparam int SEL_W    = $clog2(NUM_REGS),
  localparam int NB       = WORD_SIZE / BYTE_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 o_mem_req,
  input  logic                 i_mem_rdy,
  input  logic [BYTE_SIZE-1:0] i_mem_data,
  output logic                 o_pc_inc,
  output logic [BYTE_SIZE-1:0] o_ir,
  output logic [SEL_W-1:0]     o_rd_sel,
  input  logic [WORD_SIZE-1:0] i_rf_rdata,
  output logic [NUM_REGS-1:0]  o_reg_ld,
  output logic [WORD_SIZE-1:0] o_wdata,
  output logic                 o_carry,
  output logic                 o_illegal,
  output logic                 o_halted
);

  localparam logic [BYTE_SIZE-1:0] OP_NOP         = BYTE_SIZE'(8'h00);
  localparam logic [BYTE_SIZE-1:0] OP_MOV_REG_LIT = BYTE_SIZE'(8'h10);
  localparam logic [BYTE_SIZE-1:0] OP_MOV_REG_REG = BYTE_SIZE'(8'h11);
  localparam logic [BYTE_SIZE-1:0] OP_ADD_REG_LIT = BYTE_SIZE'(8'h14);
  localparam logic [BYTE_SIZE-1:0] OP_ADD_REG_REG = BYTE_SIZE'(8'h15);
  localparam logic [BYTE_SIZE-1:0] OP_HALT        = BYTE_SIZE'(8'hFF);

  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_IMM  = CNT_W'(NB - 1);
  localparam logic [4:0]       REG_LIMIT = 5'(NUM_REGS);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPR,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [BYTE_SIZE-1:0] r_ir;
  logic [3:0]           r_dst;
  logic [3:0]           r_src;
  logic [WORD_SIZE-1:0] r_imm;
  logic [WORD_SIZE-1:0] r_operand;
  logic [CNT_W-1:0]     r_immCnt;
  logic                 r_carry;

  logic                 w_take;
  logic                 w_opIsLit;
  logic                 w_opIsReg;
  logic                 w_opIsAdd;
  logic                 w_opLegal;
  logic                 w_dstBad;
  logic                 w_srcBad;
  logic                 w_execBad;
  logic [WORD_SIZE-1:0] w_addend;
  logic [WORD_SIZE:0]   w_sum;
  logic [WORD_SIZE-1:0] w_result;
  logic [WORD_SIZE-1:0] w_immShift;

  assign w_take    = o_mem_req & i_mem_rdy;
  assign w_opIsLit = (r_ir == OP_MOV_REG_LIT) || (r_ir == OP_ADD_REG_LIT);
  assign w_opIsReg = (r_ir == OP_MOV_REG_REG) || (r_ir == OP_ADD_REG_REG);
  assign w_opIsAdd = (r_ir == OP_ADD_REG_LIT) || (r_ir == OP_ADD_REG_REG);
  assign w_opLegal = w_opIsLit || w_opIsReg || (r_ir == OP_NOP) || (r_ir == OP_HALT);

  assign w_dstBad  = {1'b0, r_dst} >= REG_LIMIT;
  assign w_srcBad  = w_opIsReg && ({1'b0, r_src} >= REG_LIMIT);
  assign w_execBad = w_dstBad || w_srcBad;

  // The source operand of ADD_REG_REG was captured during OPR, so EXEC can read dst.
  assign w_addend  = w_opIsLit ? r_imm : r_operand;
  assign w_sum     = {1'b0, i_rf_rdata} + {1'b0, w_addend};
  assign w_result  = w_opIsAdd ? w_sum[WORD_SIZE-1:0] : (w_opIsLit ? r_imm : i_rf_rdata);

  // Bytes enter at the top and drift down, so the first byte ends up least significant.
  assign w_immShift = (r_imm >> BYTE_SIZE) | (WORD_SIZE'(i_mem_data) << (WORD_SIZE - BYTE_SIZE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_take) w_nextState = S_DECODE;
      end
      S_DECODE: begin
        if (r_ir == OP_HALT)      w_nextState = S_HALT;
        else if (w_opIsLit || w_opIsReg) w_nextState = S_OPR;
        else                      w_nextState = S_FETCH;
      end
      S_OPR: begin
        if (w_take) w_nextState = w_opIsLit ? S_IMM : S_EXEC;
      end
      S_IMM: begin
        if (w_take && (r_immCnt == LAST_IMM)) w_nextState = S_EXEC;
      end
      S_EXEC:  w_nextState = S_FETCH;
      S_HALT:  w_nextState = S_HALT;
      default: w_nextState = S_FETCH;
    endcase
  end

  always_comb begin
    o_mem_req = 1'b0;
    o_illegal = 1'b0;
    o_halted  = 1'b0;
    o_reg_ld  = '0;
    o_wdata   = '0;
    o_rd_sel  = r_dst[SEL_W-1:0];
    if (!reset) begin
      case (r_state)
        S_FETCH, S_IMM: o_mem_req = 1'b1;
        S_OPR: begin
          o_mem_req = 1'b1;
          if (r_ir == OP_ADD_REG_REG) o_rd_sel = i_mem_data[4 +: SEL_W];
        end
        S_DECODE: o_illegal = !w_opLegal;
        S_EXEC: begin
          if (r_ir == OP_MOV_REG_REG) o_rd_sel = r_src[SEL_W-1:0];
          if (w_execBad) begin
            o_illegal = 1'b1;
          end else begin
            o_reg_ld = NUM_REGS'(1) << r_dst;
            o_wdata  = w_result;
          end
        end
        S_HALT:  o_halted = 1'b1;
        default: o_mem_req = 1'b0;
      endcase
    end
  end

  assign o_pc_inc = o_mem_req & i_mem_rdy;
  assign o_ir     = r_ir;
  assign o_carry  = r_carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir      <= '0;
      r_dst     <= '0;
      r_src     <= '0;
      r_imm     <= '0;
      r_operand <= '0;
      r_immCnt  <= '0;
      r_carry   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_take) r_ir <= i_mem_data;
        end
        S_OPR: begin
          if (w_take) begin
            r_dst    <= i_mem_data[3:0];
            r_src    <= i_mem_data[7:4];
            r_immCnt <= '0;
            if (r_ir == OP_ADD_REG_REG) r_operand <= i_rf_rdata;
          end
        end
        S_IMM: begin
          if (w_take) begin
            r_imm    <= w_immShift;
            r_immCnt <= r_immCnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (!w_execBad && w_opIsAdd) r_carry <= w_sum[WORD_SIZE];
        end
        default: r_carry <= r_carry;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed programs plus randomized instructions and
// wait states, compared cycle by cycle against an instruction-level reference model.
module tb_seq_ctrl;

  localparam int BYTE_SIZE = 8;
  localparam int WORD_SIZE = 16;
  localparam int NUM_REGS  = 4;
  localparam int SEL_W     = 2;
  localparam int NB        = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 memReq;
  logic                 memRdy = 1'b0;
  logic [BYTE_SIZE-1:0] memData = '0;
  logic                 pcInc;
  logic [BYTE_SIZE-1:0] ir;
  logic [SEL_W-1:0]     rdSel;
  logic [WORD_SIZE-1:0] rfRdata;
  logic [NUM_REGS-1:0]  regLd;
  logic [WORD_SIZE-1:0] wdata;
  logic                 carry;
  logic                 illegal;
  logic                 halted;

  int errorCount = 0;
  int checkCount = 0;
  int waitMode   = 0;

  logic [WORD_SIZE-1:0] rfMem [NUM_REGS];
  logic [WORD_SIZE-1:0] modelRegs [NUM_REGS];
  logic                 modelCarry = 1'b0;
  logic [7:0]           prog [$];

  seq_ctrl #(
    .BYTE_SIZE(BYTE_SIZE),
    .WORD_SIZE(WORD_SIZE),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .o_mem_req (memReq),
    .i_mem_rdy (memRdy),
    .i_mem_data(memData),
    .o_pc_inc  (pcInc),
    .o_ir      (ir),
    .o_rd_sel  (rdSel),
    .i_rf_rdata(rfRdata),
    .o_reg_ld  (regLd),
    .o_wdata   (wdata),
    .o_carry   (carry),
    .o_illegal (illegal),
    .o_halted  (halted)
  );

  always #5 clk = ~clk;

  // Register file the sequencer talks to: combinational read, strobed write.
  assign rfRdata = rfMem[rdSel];

  always @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (regLd[i]) rfMem[i] <= wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled just after.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic [7:0] data);
    @(negedge clk);
    reset   = rst;
    memRdy  = rdy;
    memData = data;
    #1;
  endtask

  task automatic loadProg(input logic [31:0] packed_bytes, input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(packed_bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic busByte(input logic [7:0] b, input logic [7:0] op, input bit checkIr);
    int   waits;
    logic rdy;
    waits = (waitMode < 0) ? int'($urandom_range(0, 2)) : waitMode;
    for (int w = 0; w <= waits; w++) begin
      rdy = (w == waits);
      applyStimulus(1'b0, rdy, rdy ? b : 8'($urandom));
      checkOutput("mem_req_bus", memReq, 1);
      checkOutput("pc_inc_bus", pcInc, rdy);
      checkOutput("reg_ld_bus", regLd, 0);
      checkOutput("illegal_bus", illegal, 0);
      checkOutput("halted_bus", halted, 0);
      checkOutput("carry_bus", carry, modelCarry);
      if (checkIr) checkOutput("ir_bus", ir, op);
    end
  endtask

  task automatic internalCycle(input logic [3:0] expLd, input logic [15:0] expW, input bit checkW,
                               input bit expIll, input logic [7:0] op);
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    checkOutput("mem_req_int", memReq, 0);
    checkOutput("pc_inc_int", pcInc, 0);
    checkOutput("reg_ld", regLd, expLd);
    checkOutput("illegal", illegal, expIll);
    checkOutput("halted_int", halted, 0);
    checkOutput("ir", ir, op);
    checkOutput("carry_int", carry, modelCarry);
    if (checkW) checkOutput("wdata", wdata, expW);
  endtask

  // One instruction, with the timing and result derived from the instruction rules.
  task automatic runInstr();
    logic [7:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [15:0] imm;
    logic [15:0] operand;
    logic [15:0] result;
    int unsigned sum;
    bit          isLit, isReg, isAdd, bad;
    op    = prog[0];
    isLit = (op == 8'h10) || (op == 8'h14);
    isReg = (op == 8'h11) || (op == 8'h15);
    isAdd = (op == 8'h14) || (op == 8'h15);
    busByte(op, op, 1'b0);
    if (!(isLit || isReg)) begin
      internalCycle(4'h0, 16'h0, 1'b0, !((op == 8'h00) || (op == 8'hFF)), op);
      return;
    end
    internalCycle(4'h0, 16'h0, 1'b0, 1'b0, op);
    for (int k = 1; k < prog.size(); k++) busByte(prog[k], op, 1'b1);
    dst = prog[1][3:0];
    src = prog[1][7:4];
    imm = 16'h0;
    if (isLit) begin
      for (int k = 0; k < NB; k++) imm = imm | (16'(prog[2+k]) << (8*k));
    end
    bad = (int'(dst) >= NUM_REGS) || (isReg && (int'(src) >= NUM_REGS));
    if (bad) begin
      internalCycle(4'h0, 16'h0, 1'b0, 1'b1, op);
    end else begin
      operand = isLit ? imm : modelRegs[src];
      sum     = int'(modelRegs[dst]) + int'(operand);
      result  = isAdd ? 16'(sum) : operand;
      internalCycle(4'(1) << dst, result, 1'b1, 1'b0, op);
      modelRegs[dst] = result;
      if (isAdd) modelCarry = (sum > 32'h0000FFFF);
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b1, 8'($urandom));
      checkOutput("rst_mem_req", memReq, 0);
      checkOutput("rst_pc_inc", pcInc, 0);
      checkOutput("rst_reg_ld", regLd, 0);
      checkOutput("rst_wdata", wdata, 0);
      checkOutput("rst_illegal", illegal, 0);
      checkOutput("rst_halted", halted, 0);
      if (i > 0) begin
        checkOutput("rst_ir", ir, 0);
        checkOutput("rst_carry", carry, 0);
      end
    end
    modelCarry = 1'b0;
  endtask

  task automatic genRandom();
    int   r;
    logic [7:0] op;
    logic [3:0] dst, src;
    r = int'($urandom_range(0, 99));
    if (r < 8)       op = 8'h00;
    else if (r < 14) op = 8'($urandom_range(8'h20, 8'hFE));
    else begin
      case ($urandom_range(0, 3))
        0:       op = 8'h10;
        1:       op = 8'h11;
        2:       op = 8'h14;
        default: op = 8'h15;
      endcase
    end
    dst = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NUM_REGS-1));
    src = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NUM_REGS-1));
    prog.delete();
    prog.push_back(op);
    if ((op == 8'h10) || (op == 8'h11) || (op == 8'h14) || (op == 8'h15)) begin
      prog.push_back({src, dst});
      if ((op == 8'h10) || (op == 8'h14)) begin
        for (int k = 0; k < NB; k++) prog.push_back(8'($urandom));
      end
    end
  endtask

  initial begin
    doReset(3);

    // Directed programs with zero wait states.
    waitMode = 0;
    loadProg(32'h10023412, 4); runInstr();
    loadProg(32'h1001FFFF, 4); runInstr();
    loadProg(32'h14010200, 4); runInstr();
    loadProg(32'h10000300, 4); runInstr();
    loadProg(32'h10030500, 4); runInstr();
    loadProg(32'h00001530, 2); runInstr();
    loadProg(32'h00000000, 1); runInstr();
    loadProg(32'h00000042, 1); runInstr();
    loadProg(32'h10051111, 4); runInstr();

    // Two wait cycles on every byte.
    waitMode = 2;
    loadProg(32'h10027856, 4); runInstr();

    // Randomized traffic after giving every register a known value.
    waitMode = -1;
    for (int i = 0; i < NUM_REGS; i++) begin
      loadProg({8'h10, 8'(i), 16'($urandom)}, 4);
      runInstr();
    end
    for (int n = 0; n < 150; n++) begin
      genRandom();
      runInstr();
    end

    // Reset in the middle of an immediate: the write must be abandoned.
    busByte(8'h14, 8'h14, 1'b0);
    internalCycle(4'h0, 16'h0, 1'b0, 1'b0, 8'h14);
    busByte(8'h01, 8'h14, 1'b1);
    busByte(8'hAB, 8'h14, 1'b1);
    doReset(2);
    for (int n = 0; n < 20; n++) begin
      genRandom();
      runInstr();
    end

    // HALT freezes the sequencer until reset.
    loadProg(32'h000000FF, 1); runInstr();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      checkOutput("halt_halted", halted, 1);
      checkOutput("halt_mem_req", memReq, 0);
      checkOutput("halt_pc_inc", pcInc, 0);
      checkOutput("halt_reg_ld", regLd, 0);
      checkOutput("halt_ir", ir, 8'hFF);
      checkOutput("halt_carry", carry, modelCarry);
    end
    doReset(2);
    loadProg(32'h1002BEEF, 4); runInstr();
    loadProg(32'h00001120, 2); runInstr();

    @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) checkOutput($sformatf("regfile_r%0d", i), rfMem[i], modelRegs[i]);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Parametrised multi-cycle instruction sequencer; the next-generation CPU control unit. Fetches an opcode, a register byte and an optional little-endian multi-byte immediate over a ready/request byte bus with wait states. Executes MOV/ADD in register-immediate and register-register forms against an N-entry register file, with its own adder, carry flag, halt and illegal-instruction detection. Sits between the program memory/PC and the general-purpose register file.

## Interface
- BYTE_SIZE, 8, memory bus / opcode width
- WORD_SIZE, 16, register width; integer multiple of BYTE_SIZE
- NUM_REGS, 4, register count, 2..16; localparam SEL_W = $clog2(NUM_REGS), NB = WORD_SIZE/BYTE_SIZE
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- mem_req  out  1  byte requested this cycle
- mem_rdy  in  1  mem_data valid; byte consumed when mem_req & mem_rdy
- mem_data  in  BYTE_SIZE  program byte
- pc_inc  out  1  pulse on every consumed byte
- ir  out  BYTE_SIZE  current opcode
- rd_sel  out  SEL_W  register-file read address
- rf_rdata  in  WORD_SIZE  combinational read data for rd_sel
- reg_ld  out  NUM_REGS  one-hot write strobe, one cycle
- wdata  out  WORD_SIZE  write data, valid when reg_ld != 0
- carry  out  1  carry-out of last ADD
- illegal  out  1  one-cycle pulse on bad opcode/register index
- halted  out  1  high in HALT

## Operation
- Opcodes (shared global defines): NOP 8'h00, MOV_REG_LIT 8'h10, MOV_REG_REG 8'h11, ADD_REG_LIT 8'h14, ADD_REG_REG 8'h15, HALT 8'hFF; all others illegal.
- Register byte: bits[3:0] = dst, bits[7:4] = src (REG_REG only). Index >= NUM_REGS is illegal.
- Immediate: NB bytes following the register byte, least-significant first, assembled in an internal shift register.
- States: FETCH, DECODE, OPR, IMM, EXEC, HALT.
- FETCH: mem_req=1; on rdy ir<=mem_data, go DECODE; else hold.
- DECODE (1 cycle, no mem_req): NOP -> FETCH; HALT -> HALT; illegal -> pulse illegal, FETCH; else -> OPR.
- OPR: mem_req=1; on rdy latch dst/src; LIT forms -> IMM (byte counter = 0), REG forms -> EXEC.
- IMM: mem_req=1; each rdy shifts in one byte, counter++; after byte NB-1 -> EXEC.
- EXEC (1 cycle): bad dst or src -> pulse illegal, no write. Otherwise rd_sel = src for MOV_REG_REG, else dst; result = imm, rf_rdata, or rf_rdata + (imm or src value). For ADD_REG_REG the src value is captured in OPR->EXEC via an extra read: rd_sel=src in the OPR completion cycle, latched into the operand register. reg_ld[dst]=1, wdata=result; ADD sets carry = bit WORD_SIZE of the (WORD_SIZE+1)-bit sum, result wraps modulo 2^WORD_SIZE. MOV leaves carry. -> FETCH.
- HALT: mem_req=0, halted=1, no outputs change until reset.
- mem_rdy ignored when mem_req=0. pc_inc = mem_req & mem_rdy exactly.

## Timing
- Reset values: state FETCH, ir 0, carry 0, reg_ld 0, wdata 0, illegal 0, halted 0, pc_inc 0, mem_req 0 during reset; first cycle after deassertion is FETCH with mem_req=1.
- Reset mid-instruction: abandoned; no reg_ld, carry unchanged from reset value 0.
- Zero-wait latency (NB=2): LIT forms 6 cycles, REG forms 4 cycles, NOP/illegal opcode 2 cycles, opcode-to-opcode.
- Each wait cycle (mem_req & !mem_rdy) adds exactly one cycle; no state or counter change.
- reg_ld asserts only in EXEC, never on back-to-back cycles.
- Reset has priority over every other event, including an in-flight rdy.

## Test plan
- MOV_REG_LIT: bytes 10,02,34,12, rdy=1 -> reg_ld=4'b0100, wdata=16'h1234 on cycle 6, pc_inc 4 times, carry unchanged.
- ADD_REG_LIT wrap: rf_rdata=16'hFFFF for r1, bytes 14,01,02,00 -> wdata=16'h0001, carry=1, reg_ld=4'b0010.
- ADD_REG_REG: r0=16'h0003, r3=16'h0005, bytes 15,30 -> reg_ld=4'b0001, wdata=16'h0008, carry=0, 4 cycles.
- Wait states: mem_rdy low 2 cycles per byte on MOV_REG_LIT -> same result, 14 cycles, ir/regs stable while waiting.
- Illegal: opcode 8'h42 -> illegal pulse in DECODE, next FETCH; MOV_REG_LIT dst 5 with NUM_REGS=4 -> illegal in EXEC, no reg_ld.
- HALT then reset: 8'hFF -> halted=1, mem_req=0 indefinitely; reset asserted mid-IMM of a later program -> no write, FETCH on deassert.
